// File: rtl/brick_hit_handler.sv
// Turns collision-detector overlap flags into brick hits, ball reflects and score.
// The PLAY/COOLDOWN/CLEARED sequencing makes one overlap produce exactly one hit.
module brick_hit_handler #(
  parameter int NUM_BLOCKS = 10,
  parameter int COOLDOWN   = 4,
  parameter int SCORE_W    = 8,
  parameter int POINTS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  collide_paddle,
  input  logic [NUM_BLOCKS-1:0] collide_block,
  input  logic                  restart,
  output logic [NUM_BLOCKS-1:0] alive,
  output logic                  flip_y,
  output logic                  hit_valid,
  output logic [3:0]            hit_idx,
  output logic [SCORE_W-1:0]    score,
  output logic                  level_clear
);

  localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [1:0] ST_PLAY     = 2'd0;
  localparam logic [1:0] ST_COOLDOWN = 2'd1;
  localparam logic [1:0] ST_CLEARED  = 2'd2;

  localparam logic [NUM_BLOCKS-1:0] ALL_ALIVE  = {NUM_BLOCKS{1'b1}};
  localparam logic [NUM_BLOCKS-1:0] NONE_ALIVE = {NUM_BLOCKS{1'b0}};
  localparam logic [NUM_BLOCKS-1:0] ONE_HOT_0  = {{(NUM_BLOCKS-1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0]    SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W:0]      POINTS_EXT = (SCORE_W+1)'(POINTS);
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

  // Lowest set bit wins, so simultaneous overlaps destroy only the lowest block.
  function automatic logic [3:0] lowest_idx(input logic [NUM_BLOCKS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + POINTS_EXT;
    if (sum > {1'b0, SCORE_MAX}) begin
      return SCORE_MAX;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  logic [1:0]            state_r,       state_nx_s;
  logic [CNT_W-1:0]      cnt_r,         cnt_nx_s;
  logic [NUM_BLOCKS-1:0] alive_r,       alive_nx_s;
  logic [SCORE_W-1:0]    score_r,       score_nx_s;
  logic                  flip_y_r,      flip_y_nx_s;
  logic                  hit_valid_r,   hit_valid_nx_s;
  logic [3:0]            hit_idx_r,     hit_idx_nx_s;
  logic                  level_clear_r, level_clear_nx_s;
  logic [NUM_BLOCKS-1:0] masked_s;
  logic [3:0]            hit_sel_s;

  assign masked_s  = collide_block & alive_r;
  assign hit_sel_s = lowest_idx(masked_s);

  // Next-state and next-output decode.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    alive_nx_s     = alive_r;
    score_nx_s     = score_r;
    flip_y_nx_s    = 1'b0;
    hit_valid_nx_s = 1'b0;
    hit_idx_nx_s   = hit_idx_r;
    case (state_r)
      ST_PLAY: begin
        if (masked_s != NONE_ALIVE) begin
          alive_nx_s     = alive_r & ~(ONE_HOT_0 << hit_sel_s);
          hit_idx_nx_s   = hit_sel_s;
          hit_valid_nx_s = 1'b1;
          flip_y_nx_s    = 1'b1;
          score_nx_s     = sat_add(score_r);
          cnt_nx_s       = CNT_LOAD;
          state_nx_s     = ST_COOLDOWN;
        end else if (collide_paddle) begin
          flip_y_nx_s = 1'b1;
          cnt_nx_s    = CNT_LOAD;
          state_nx_s  = ST_COOLDOWN;
        end else begin
          state_nx_s = ST_PLAY;
        end
      end
      ST_COOLDOWN: begin
        // Exit is judged on the registered count, so a zero load leaves one cycle later.
        if (cnt_r == CNT_ZERO) begin
          if (alive_r == NONE_ALIVE) begin
            state_nx_s = ST_CLEARED;
          end else begin
            state_nx_s = ST_PLAY;
          end
        end else if (frame_tick) begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      ST_CLEARED: begin
        if (restart) begin
          alive_nx_s = ALL_ALIVE;
          state_nx_s = ST_PLAY;
        end else begin
          state_nx_s = ST_CLEARED;
        end
      end
      default: begin
        state_nx_s = ST_PLAY;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
    level_clear_nx_s = (state_nx_s == ST_CLEARED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_PLAY;
      cnt_r         <= CNT_ZERO;
      alive_r       <= ALL_ALIVE;
      score_r       <= {SCORE_W{1'b0}};
      flip_y_r      <= 1'b0;
      hit_valid_r   <= 1'b0;
      hit_idx_r     <= 4'd0;
      level_clear_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      alive_r       <= alive_nx_s;
      score_r       <= score_nx_s;
      flip_y_r      <= flip_y_nx_s;
      hit_valid_r   <= hit_valid_nx_s;
      hit_idx_r     <= hit_idx_nx_s;
      level_clear_r <= level_clear_nx_s;
    end
  end

  assign alive       = alive_r;
  assign flip_y      = flip_y_r;
  assign hit_valid   = hit_valid_r;
  assign hit_idx     = hit_idx_r;
  assign score       = score_r;
  assign level_clear = level_clear_r;

endmodule
